// File: rtl/note_selector.sv
// Synth voice front end: synchronises and debounces keys and buttons, then
// registers the oscillator period, waveform select and note gate for sound_driver.
module note_selector #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 14
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [12:0] keys,
  input  logic        octave_up,
  input  logic        octave_down,
  input  logic        mode_btn,
  output logic [17:0] divider,
  output logic [1:0]  mode,
  output logic        strobe
);

  localparam int BIT_UP   = 13;
  localparam int BIT_DOWN = 14;
  localparam int BIT_MODE = 15;
  localparam logic [2:0] OCT_RESET = 3'd2;
  localparam logic [2:0] OCT_MAX   = 3'd4;

  logic [15:0]      raw;
  logic [15:0]      sync1_q, sync2_q, s_prev_q;
  logic [15:0]      d_q, d_d, d_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       octave_q, octave_d;
  logic [1:0]       mode_q, mode_d, mode_out_q;
  logic [17:0]      divider_q, divider_d;
  logic             strobe_q, strobe_d;
  logic [15:0]      rise;
  logic [3:0]       idx;
  logic             any_key;

  assign raw = {mode_btn, octave_down, octave_up, keys};

  // Octave-2 periods in clk cycles at 10 MHz, C up to C one octave higher.
  function automatic logic [17:0] base_period(input logic [3:0] i);
    case (i)
      4'd0:    base_period = 18'd152890;
      4'd1:    base_period = 18'd144309;
      4'd2:    base_period = 18'd136210;
      4'd3:    base_period = 18'd128565;
      4'd4:    base_period = 18'd121349;
      4'd5:    base_period = 18'd114538;
      4'd6:    base_period = 18'd108109;
      4'd7:    base_period = 18'd102042;
      4'd8:    base_period = 18'd96315;
      4'd9:    base_period = 18'd90909;
      4'd10:   base_period = 18'd85807;
      4'd11:   base_period = 18'd80991;
      default: base_period = 18'd76445;
    endcase
  endfunction

  // Shared debounce: any change in the synced vector restarts the count, so
  // the whole vector must sit still for DEBOUNCE_CYCLES before it is accepted.
  always_comb begin
    // NOTE: defaults first so every path assigns each output; no latches inferred.
    d_d   = d_q;
    cnt_d = '0;
    if (sync2_q != d_q && sync2_q == s_prev_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        d_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rise = d_q & ~d_prev_q;

  always_comb begin
    octave_d = octave_q;
    mode_d   = mode_q;
    if (rise[BIT_UP] && !rise[BIT_DOWN] && octave_q < OCT_MAX) begin
      octave_d = octave_q + 3'd1;
    end else if (rise[BIT_DOWN] && !rise[BIT_UP] && octave_q != 3'd0) begin
      octave_d = octave_q - 3'd1;
    end
    if (rise[BIT_MODE]) begin
      mode_d = mode_q + 2'd1;
    end
  end

  // Highest active key wins: later loop iterations override earlier ones.
  always_comb begin
    idx     = 4'd0;
    any_key = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (d_q[i]) begin
        idx     = 4'(i);
        any_key = 1'b1;
      end
    end
  end

  always_comb begin
    divider_d = divider_q;
    strobe_d  = any_key;
    if (any_key) begin
      divider_d = base_period(idx) >> octave_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which the synchroniser chain depends on.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      s_prev_q   <= '0;
      d_q        <= '0;
      d_prev_q   <= '0;
      cnt_q      <= '0;
      octave_q   <= OCT_RESET;
      mode_q     <= '0;
      mode_out_q <= '0;
      divider_q  <= '0;
      strobe_q   <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      s_prev_q   <= sync2_q;
      d_q        <= d_d;
      d_prev_q   <= d_q;
      cnt_q      <= cnt_d;
      octave_q   <= octave_d;
      mode_q     <= mode_d;
      mode_out_q <= mode_q;
      divider_q  <= divider_d;
      strobe_q   <= strobe_d;
    end
  end

  assign divider = divider_q;
  assign mode    = mode_out_q;
  assign strobe  = strobe_q;

endmodule

// File: tb/tb_note_selector.sv
// Directed bench for note_selector with a short debounce window.
module tb_note_selector;

  logic        clk = 1'b0;
  logic        nrst;
  logic [12:0] keys;
  logic        octave_up, octave_down, mode_btn;
  logic [17:0] divider;
  logic [1:0]  mode;
  logic        strobe;

  int total = 0;
  int bad   = 0;

  note_selector #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .nrst(nrst), .keys(keys), .octave_up(octave_up),
    .octave_down(octave_down), .mode_btn(mode_btn),
    .divider(divider), .mode(mode), .strobe(strobe)
  );

  always #50 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Press and release a button with enough settle time for each edge.
  task automatic press(input int which);
    case (which)
      0: octave_up = 1'b1;
      1: octave_down = 1'b1;
      2: mode_btn = 1'b1;
      default: begin octave_up = 1'b1; octave_down = 1'b1; end
    endcase
    tick(12);
    octave_up = 1'b0; octave_down = 1'b0; mode_btn = 1'b0;
    tick(12);
  endtask

  initial begin
    logic saw_strobe;
    logic [1:0] mode_seq [5];
    logic [17:0] up_seq [3];
    logic [17:0] dn_seq [5];
    mode_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    up_seq   = '{18'd11363, 18'd5681, 18'd5681};
    dn_seq   = '{18'd11363, 18'd22727, 18'd45454, 18'd90909, 18'd90909};

    nrst = 1'b0; keys = '0; octave_up = 0; octave_down = 0; mode_btn = 0;
    tick(2);
    check("reset_divider", divider, 0);
    check("reset_strobe", strobe, 0);
    check("reset_mode", mode, 0);
    nrst = 1'b1;
    tick(1);

    // 1: single key at octave 2
    keys[9] = 1'b1;
    tick(12);
    check("t1_divider", divider, 22727);
    check("t1_strobe", strobe, 1);
    check("t1_mode", mode, 0);

    // 2: release, then a 3-cycle glitch must not reach the outputs
    keys = '0;
    tick(12);
    check("t2_release_strobe", strobe, 0);
    saw_strobe = 1'b0;
    keys[9] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      saw_strobe |= strobe;
    end
    keys = '0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      saw_strobe |= strobe;
    end
    check("t2_glitch_strobe", saw_strobe, 0);
    check("t2_glitch_divider", divider, 22727);
    check("t2_cnt_idle", dut.cnt_q, 0);

    // 3: highest key wins
    keys[0] = 1'b1; keys[12] = 1'b1;
    tick(12);
    check("t3_both", divider, 19111);
    keys[12] = 1'b0;
    tick(12);
    check("t3_low_c", divider, 38222);
    keys = '0;
    tick(12);

    // 4: octave saturation both ways
    keys[9] = 1'b1;
    tick(12);
    check("t4_start", divider, 22727);
    for (int i = 0; i < 3; i++) begin
      press(0);
      check($sformatf("t4_up%0d", i), divider, up_seq[i]);
    end
    for (int i = 0; i < 5; i++) begin
      press(1);
      check($sformatf("t4_down%0d", i), divider, dn_seq[i]);
    end

    // 5: mode wrap and simultaneous octave buttons
    for (int i = 0; i < 5; i++) begin
      press(2);
      check($sformatf("t5_mode%0d", i), mode, mode_seq[i]);
    end
    press(3);
    check("t5_both_oct", divider, 90909);

    // 6: release holds pitch; async reset clears everything
    keys = '0;
    tick(12);
    check("t6_release_strobe", strobe, 0);
    check("t6_release_divider", divider, 90909);
    keys[9] = 1'b1;
    tick(12);
    check("t6_held_strobe", strobe, 1);
    #20;
    nrst = 1'b0;
    #1;
    check("t6_async_divider", divider, 0);
    check("t6_async_strobe", strobe, 0);
    check("t6_async_mode", mode, 0);
    keys = '0;
    tick(2);
    nrst = 1'b1;
    tick(12);
    check("t6_no_resume", strobe, 0);
    keys[9] = 1'b1;
    tick(12);
    check("t6_octave_reset", divider, 22727);
    check("t6_mode_after", mode, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
